// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI master controller slice.
//   - spi_state_t : controller FSM states (IDLE, SHIFT, GAP, DONE)
//   - FRAME_BITS  : exe-unit frame length {argA, argB, oper, result, flags}
//   - *_MSB       : bit offsets of each field inside the frame
//   - CS_IDLE     : chip-select code driven when no slave is addressed
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } spi_state_t;

    localparam int unsigned FRAME_BITS = 20;

    localparam int unsigned ARGA_MSB  = 19;
    localparam int unsigned ARGB_MSB  = 15;
    localparam int unsigned OPER_MSB  = 11;
    localparam int unsigned RES_MSB   = 7;
    localparam int unsigned FLAGS_MSB = 3;

    localparam logic [2:0] CS_IDLE = 3'd0;

endpackage

// File: rtl/spi_master_ctrl_sclk_gen.sv
// spi_sclk_gen: divides the system clock down to a 50% duty SPI clock.
//   i_clk_p  : system clock, rising edge
//   i_rst_n  : synchronous active-low reset
//   i_en     : run the divider; when low the divider clears and SCLK idles low
//   o_sclk   : SPI clock, half-period of CLK_DIV system cycles
//   o_rise   : one-cycle strobe in the cycle whose edge drives SCLK high
//   o_fall   : one-cycle strobe in the cycle whose edge drives SCLK low
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic i_clk_p,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             div_tc;

    assign div_tc = (div_cnt == DIV_LAST);

    // Strobes are combinational so the controller acts on the same edge
    // that toggles SCLK.
    assign o_rise = i_en & div_tc & ~o_sclk;
    assign o_fall = i_en & div_tc &  o_sclk;

    always_ff @(posedge i_clk_p) begin
        if (!i_rst_n || !i_en) begin
            div_cnt <= '0;
            o_sclk  <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= '0;
            o_sclk  <= ~o_sclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master that shifts one exe-unit frame out on MOSI
// (MSB first) while capturing the slave's frame from MISO, then issues
// GAP_CYCLES trailing SCLK periods with chip-select idle so the slave's
// negedge FSM can finish.
//   i_clk_p     : system clock, rising edge
//   i_rst_n     : synchronous active-low reset
//   i_start     : transaction request, sampled only in IDLE
//   i_slave_sel : chip-select code used for the frame
//   i_tx_data   : frame to send, latched on accepted start
//   i_loopback  : (SPI_MASTER_LOOPBACK_EN only) sample MOSI instead of MISO,
//                 chip-select held idle
//   o_rx_data   : received frame, updated at o_done and held
//   o_busy      : high from the cycle after accepted start until o_done
//   o_done      : one-cycle end-of-transaction pulse
//   o_sclk      : SPI clock, idles low
//   o_mosi      : serial data to slave
//   i_miso      : serial data from slave
//   o_cs        : slave select code, CS_IDLE when idle
// Optional build macro: SPI_MASTER_LOOPBACK_EN.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned BITS       = FRAME_BITS,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 3
) (
    input  logic            i_clk_p,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_slave_sel,
    input  logic [BITS-1:0] i_tx_data,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic            i_loopback,
`endif
    output logic [BITS-1:0] o_rx_data,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_sclk,
    output logic            o_mosi,
    input  logic            i_miso,
    output logic [2:0]      o_cs
);

    localparam int unsigned CNT_MAX = (BITS > GAP_CYCLES) ? BITS : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    spi_state_t      state, state_nxt;
    logic [BITS-1:0] tx_sr, tx_nxt;
    logic [BITS-1:0] rx_sr, rx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]      cs_nxt;
    logic            mosi_nxt;
    logic            busy_nxt;
    logic            done_nxt;
    logic [BITS-1:0] rx_data_nxt;

    logic sclk_en;
    logic sclk_rise;
    logic sclk_fall;
    logic rx_bit;

    assign sclk_en = (state == SHIFT) || (state == GAP);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .i_clk_p (i_clk_p),
        .i_rst_n (i_rst_n),
        .i_en    (sclk_en),
        .o_sclk  (o_sclk),
        .o_rise  (sclk_rise),
        .o_fall  (sclk_fall)
    );

`ifdef SPI_MASTER_LOOPBACK_EN
    assign rx_bit = i_loopback ? o_mosi : i_miso;
`else
    assign rx_bit = i_miso;
`endif

    always_comb begin
        state_nxt   = state;
        tx_nxt      = tx_sr;
        rx_nxt      = rx_sr;
        cnt_nxt     = cnt;
        cs_nxt      = o_cs;
        mosi_nxt    = o_mosi;
        busy_nxt    = o_busy;
        done_nxt    = 1'b0;
        rx_data_nxt = o_rx_data;

        case (state)
            IDLE: begin
                if (i_start) begin
                    tx_nxt    = i_tx_data;
                    rx_nxt    = '0;
                    cnt_nxt   = '0;
                    mosi_nxt  = i_tx_data[BITS-1];
                    busy_nxt  = 1'b1;
                    state_nxt = SHIFT;
`ifdef SPI_MASTER_LOOPBACK_EN
                    cs_nxt    = i_loopback ? CS_IDLE : i_slave_sel;
`else
                    cs_nxt    = i_slave_sel;
`endif
                end
            end

            SHIFT: begin
                if (sclk_rise) begin
                    rx_nxt = {rx_sr[BITS-2:0], rx_bit};
                end
                // cnt counts completed falls; the last fall releases the slave.
                if (sclk_fall) begin
                    if (cnt == BIT_LAST) begin
                        cnt_nxt   = '0;
                        cs_nxt    = CS_IDLE;
                        mosi_nxt  = 1'b0;
                        state_nxt = (GAP_CYCLES == 0) ? DONE : GAP;
                    end else begin
                        tx_nxt   = {tx_sr[BITS-2:0], 1'b0};
                        mosi_nxt = tx_sr[BITS-2];
                        cnt_nxt  = cnt + CNT_W'(1);
                    end
                end
            end

            GAP: begin
                if (sclk_fall) begin
                    if (cnt == GAP_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end

            DONE: begin
                rx_data_nxt = rx_sr;
                done_nxt    = 1'b1;
                busy_nxt    = 1'b0;
                state_nxt   = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_p) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            tx_sr     <= '0;
            rx_sr     <= '0;
            cnt       <= '0;
            o_cs      <= CS_IDLE;
            o_mosi    <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_rx_data <= '0;
        end else begin
            state     <= state_nxt;
            tx_sr     <= tx_nxt;
            rx_sr     <= rx_nxt;
            cnt       <= cnt_nxt;
            o_cs      <= cs_nxt;
            o_mosi    <= mosi_nxt;
            o_busy    <= busy_nxt;
            o_done    <= done_nxt;
            o_rx_data <= rx_data_nxt;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: self-checking bench for spi_master_ctrl with
// CLK_DIV=2, GAP_CYCLES=3. A behavioural slave drives MISO on SCLK falls;
// a monitor records MOSI and chip-select at every SCLK rise, and each
// transaction is compared against the frame, latency and chip-select
// sequence expected from the protocol rules.
module tb_spi_master_ctrl;

    localparam int unsigned BITS = 20;
    localparam int unsigned CD   = 2;
    localparam int unsigned GAPC = 3;
    localparam int unsigned LAT  = (BITS + GAPC) * 2 * CD + 1;

    logic            clk;
    logic            rst_n;
    logic            i_start;
    logic [2:0]      i_slave_sel;
    logic [BITS-1:0] i_tx_data;
    logic [BITS-1:0] o_rx_data;
    logic            o_busy;
    logic            o_done;
    logic            o_sclk;
    logic            o_mosi;
    logic            i_miso;
    logic [2:0]      o_cs;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic            i_loopback;
`endif

    int errors;
    int checks;

    logic [BITS-1:0] slave_word;
    int              slave_idx;
    bit              mosi_q[$];
    logic [2:0]      cs_q[$];

    spi_master_ctrl #(
        .BITS       (BITS),
        .CLK_DIV    (CD),
        .GAP_CYCLES (GAPC)
    ) dut (
        .i_clk_p     (clk),
        .i_rst_n     (rst_n),
        .i_start     (i_start),
        .i_slave_sel (i_slave_sel),
        .i_tx_data   (i_tx_data),
`ifdef SPI_MASTER_LOOPBACK_EN
        .i_loopback  (i_loopback),
`endif
        .o_rx_data   (o_rx_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_sclk      (o_sclk),
        .o_mosi      (o_mosi),
        .i_miso      (i_miso),
        .o_cs        (o_cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slave: next bit after each SCLK fall, zeros once the frame is out.
    always @(negedge o_sclk) begin
        if (slave_idx < int'(BITS) - 1) begin
            slave_idx = slave_idx + 1;
            i_miso    = slave_word[BITS-1-slave_idx];
        end else begin
            i_miso = 1'b0;
        end
    end

    always @(posedge o_sclk) begin
        mosi_q.push_back(o_mosi);
        cs_q.push_back(o_cs);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_txn(input logic [BITS-1:0] tx, input logic [2:0] sel,
                          input logic [BITS-1:0] sdata, input bit lb, input int glitch_at);
        int              cyc;
        int              nbad;
        int              gap_ones;
        logic [BITS-1:0] mword;
        logic [BITS-1:0] exp_rx;
        logic [2:0]      exp_cs;

        exp_rx = lb ? tx : sdata;
        exp_cs = lb ? 3'd0 : sel;
        mosi_q.delete();
        cs_q.delete();
        slave_word  = sdata;
        slave_idx   = 0;
        i_miso      = sdata[BITS-1];
        i_tx_data   = tx;
        i_slave_sel = sel;
        i_start     = 1'b1;
`ifdef SPI_MASTER_LOOPBACK_EN
        i_loopback  = lb;
`endif
        @(posedge clk);
        #1;
        i_start = 1'b0;
        chk("busy_set", {31'd0, o_busy}, 32'd1);
        chk("done_low", {31'd0, o_done}, 32'd0);

        cyc = 0;
        while (o_done !== 1'b1 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == glitch_at) begin
                i_start     = 1'b1;
                i_tx_data   = ~tx;
                i_slave_sel = ~sel;
            end else if (cyc == glitch_at + 1) begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;

        chk("latency", 32'(cyc), 32'(LAT));
        chk("busy_drop", {31'd0, o_busy}, 32'd0);
        chk("rx_data", 32'(o_rx_data), 32'(exp_rx));
        chk("sclk_rises", 32'(mosi_q.size()), 32'(BITS + GAPC));

        nbad     = 0;
        gap_ones = 0;
        mword    = '0;
        foreach (mosi_q[i]) begin
            if (i < int'(BITS)) begin
                mword = {mword[BITS-2:0], mosi_q[i]};
                if (cs_q[i] !== exp_cs) nbad++;
            end else begin
                if (mosi_q[i]) gap_ones++;
                if (cs_q[i] !== 3'd0) nbad++;
            end
        end
        chk("cs_seq", 32'(nbad), 32'd0);
        chk("mosi_seq", 32'(mword), 32'(tx));
        chk("gap_mosi", 32'(gap_ones), 32'd0);
        chk("idle_cs", 32'(o_cs), 32'd0);
        chk("idle_sclk", {31'd0, o_sclk}, 32'd0);
    endtask

    initial begin
        int seen;
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_slave_sel = 3'd0;
        i_tx_data   = '0;
        i_miso      = 1'b0;
        slave_word  = '0;
        slave_idx   = 0;
`ifdef SPI_MASTER_LOOPBACK_EN
        i_loopback  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", {31'd0, o_sclk}, 32'd0);
        chk("rst_mosi", {31'd0, o_mosi}, 32'd0);
        chk("rst_cs", 32'(o_cs), 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_rx", 32'(o_rx_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_txn(20'h35A0F, 3'd1, 20'h0F0F0, 1'b0, -1);
        do_txn(20'hA5A5A, 3'd2, 20'h3C0F1, 1'b0, -1);
        // Start pulse mid-SHIFT must be ignored; next start right after done.
        do_txn(20'h12345, 3'd3, 20'h0ABCD, 1'b0, 30);
        do_txn(20'h54321, 3'd4, 20'hFFFFF, 1'b0, -1);
        do_txn(20'h00001, 3'd0, 20'h80000, 1'b0, -1);

        for (int n = 0; n < 6; n++) begin
            do_txn(BITS'($urandom), 3'($urandom_range(1, 7)), BITS'($urandom), 1'b0, -1);
        end

`ifdef SPI_MASTER_LOOPBACK_EN
        do_txn(20'hFEDCB, 3'd5, 20'h00000, 1'b1, -1);
        do_txn(20'h13579, 3'd6, 20'h2468A, 1'b0, -1);
`endif

        // Reset in the middle of a frame.
        i_tx_data   = 20'hCAFE5;
        i_slave_sel = 3'd6;
        i_start     = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        seen    = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (o_done) seen = 1;
        end
        chk("midrst_sclk", {31'd0, o_sclk}, 32'd0);
        chk("midrst_cs", 32'(o_cs), 32'd0);
        chk("midrst_busy", {31'd0, o_busy}, 32'd0);
        chk("midrst_rx", 32'(o_rx_data), 32'd0);
        chk("midrst_mosi", {31'd0, o_mosi}, 32'd0);
        rst_n = 1'b1;
        repeat (120) begin
            @(posedge clk);
            #1;
            if (o_done) seen = 1;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        chk("midrst_idle_busy", {31'd0, o_busy}, 32'd0);

        do_txn(20'h6B2D4, 3'd7, 20'h19E3C, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
